// File: rtl/ad_frame_sequencer.sv
// ad_frame_sequencer: recovers 18-bit samples from an AD-format serial stream,
// qualifies the frame timing with a lock FSM and hands one sample per request
// to an I2S encoder, flagging dropped (overrun) and repeated (underrun) samples.
module ad_frame_sequencer #(
  parameter int P_WIDTH       = 18,
  parameter int P_FRAME_CLKS  = 32,
  parameter int P_LOCK_FRAMES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ad_latch_pulse,
  input  logic               i_ad_data,
  input  logic               i_i2s_latch,
  output logic [P_WIDTH-1:0] o_data,
  output logic               o_locked,
  output logic               o_overrun,
  output logic               o_underrun
);

  localparam int GOOD_W = $clog2(P_LOCK_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } state_t;

  state_t state, state_next;

  // Only the P_WIDTH-1 newest bits are kept; together with the live input bit
  // they form the full word, and the oldest bit would be shifted out unused.
  logic [P_WIDTH-2:0] sr;
  logic [P_WIDTH-1:0] word_in;
  logic [P_WIDTH-1:0] hold;
  logic               latch_d;
  logic               latch_edge;
  logic [7:0]         counter;
  logic [8:0]         period;
  logic               period_ok;
  logic               timeout;
  logic [GOOD_W-1:0]  good, good_next, good_inc;
  logic               pending;

  assign word_in    = {sr, i_ad_data};
  assign latch_edge = i_ad_latch_pulse & ~latch_d;
  // period counts cycles since the previous edge, including the current one
  assign period     = {1'b0, counter} + 9'd1;
  assign period_ok  = (period == 9'(P_FRAME_CLKS));
  assign timeout    = (period >= 9'(2 * P_FRAME_CLKS));
  assign good_inc   = good + GOOD_W'(1);

  // Serial capture, edge detection, period counter and word holding register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr      <= '0;
      latch_d <= 1'b0;
      counter <= '0;
      hold    <= '0;
    end else begin
      sr      <= word_in[P_WIDTH-2:0];
      latch_d <= i_ad_latch_pulse;
      if (latch_edge) begin
        counter <= '0;
        hold    <= word_in;
      end else if (counter != 8'hFF) begin
        counter <= counter + 8'd1;
      end
    end
  end

  // Lock FSM state register; o_locked follows the state being entered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      good     <= '0;
      o_locked <= 1'b0;
    end else begin
      state    <= state_next;
      good     <= good_next;
      o_locked <= (state_next == LOCKED);
    end
  end

  // Lock FSM next-state logic: count consecutive good periods, drop on bad period or timeout
  always_comb begin
    state_next = state;
    good_next  = good;
    case (state)
      IDLE: begin
        if (latch_edge) begin
          state_next = ACQ;
          good_next  = '0;
        end
      end
      ACQ: begin
        if (latch_edge) begin
          if (period_ok) begin
            good_next = good_inc;
            if (good_inc == GOOD_W'(P_LOCK_FRAMES)) begin
              state_next = LOCKED;
            end
          end else begin
            good_next = '0;
          end
        end else if (timeout) begin
          state_next = IDLE;
          good_next  = '0;
        end
      end
      LOCKED: begin
        if (latch_edge) begin
          if (!period_ok) begin
            state_next = ACQ;
            good_next  = '0;
          end
        end else if (timeout) begin
          state_next = IDLE;
          good_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        good_next  = '0;
      end
    endcase
  end

  // Sample hand-off to the encoder with sticky overrun/underrun reporting
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data     <= '0;
      pending    <= 1'b0;
      o_overrun  <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      if (i_i2s_latch) begin
        if (state == LOCKED) begin
          if (pending) begin
            o_data <= hold;
          end else begin
            o_underrun <= 1'b1;
          end
        end else begin
          o_data <= '0;
        end
      end

      if (latch_edge && pending && !i_i2s_latch) begin
        o_overrun <= 1'b1;
      end

      // A fresh word arriving on the same cycle as a request stays pending
      if (state_next != LOCKED) begin
        pending <= 1'b0;
      end else if (latch_edge) begin
        pending <= 1'b1;
      end else if (i_i2s_latch) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ad_frame_sequencer.sv
// Self-checking bench for ad_frame_sequencer: expected encoder samples are
// queued when a request is driven and compared when the DUT presents o_data.
module tb_ad_frame_sequencer;

  localparam int W = 18;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_ad_latch_pulse = 1'b0;
  logic         i_ad_data = 1'b0;
  logic         i_i2s_latch = 1'b0;
  logic [W-1:0] o_data;
  logic         o_locked;
  logic         o_overrun;
  logic         o_underrun;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  ad_frame_sequencer #(
    .P_WIDTH(W),
    .P_FRAME_CLKS(32),
    .P_LOCK_FRAMES(4)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_ad_latch_pulse(i_ad_latch_pulse),
    .i_ad_data(i_ad_data),
    .i_i2s_latch(i_i2s_latch),
    .o_data(o_data),
    .o_locked(o_locked),
    .o_overrun(o_overrun),
    .o_underrun(o_underrun)
  );

  // Free-running sync clock
  always #5 i_clk = ~i_clk;

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ad_latch_pulse = 1'b0;
    i_ad_data        = 1'b0;
    i_i2s_latch      = 1'b0;
  endtask

  // Drives one frame of len cycles: word MSB first in the last W cycles, latch
  // pulse on the final cycle, and encoder requests on cycles l1/l2 (0 = none).
  task automatic send_frame(input logic [W-1:0] word, input int len,
                            input int l1, input int l2, input bit with_edge);
    logic [W-1:0] exp;
    for (int k = 1; k <= len; k++) begin
      i_ad_data        = (k > len - W) ? word[len-k] : 1'b0;
      i_ad_latch_pulse = with_edge && (k == len);
      i_i2s_latch      = (k == l1) || (k == l2);
      cycle();
      if (i_i2s_latch) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL sb_empty: o_data=%h with no expected sample queued", o_data);
        end else begin
          exp = exp_q.pop_front();
          if (o_data !== exp) begin
            bad++;
            $display("[TB] FAIL sb_data: o_data=%h expected=%h", o_data, exp);
          end
        end
      end
    end
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst = 1'b1;
    cycle();
    cycle();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst            = 1'b1;
    i_ad_latch_pulse = 1'b1;
    i_ad_data        = 1'b1;
    i_i2s_latch      = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    total++;
    if (o_data !== '0) begin bad++; $display("[TB] FAIL reset_data: o_data=%h expected=0", o_data); end
    total++;
    if (o_locked !== 1'b0) begin bad++; $display("[TB] FAIL reset_locked: o_locked=%b expected=0", o_locked); end
    total++;
    if (o_overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: o_overrun=%b expected=0", o_overrun); end
    total++;
    if (o_underrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_underrun: o_underrun=%b expected=0", o_underrun); end
    clear_inputs();
    i_rst = 1'b0;
  endtask

  task automatic test_lock_delivery();
    for (int f = 1; f <= 5; f++) begin
      send_frame(18'h2AAAA, 32, 0, 0, 1'b1);
      if (f == 4) begin
        total++;
        if (o_locked !== 1'b0) begin bad++; $display("[TB] FAIL lock_early: o_locked=%b expected=0", o_locked); end
      end
    end
    total++;
    if (o_locked !== 1'b1) begin bad++; $display("[TB] FAIL lock_5th_edge: o_locked=%b expected=1", o_locked); end
    total++;
    if (o_data !== '0) begin bad++; $display("[TB] FAIL data_before_req: o_data=%h expected=0", o_data); end
    exp_q.push_back(18'h2AAAA);
    send_frame(18'h15555, 32, 5, 0, 1'b1);
    total++;
    if (o_overrun !== 1'b0) begin bad++; $display("[TB] FAIL lock_overrun: o_overrun=%b expected=0", o_overrun); end
    total++;
    if (o_underrun !== 1'b0) begin bad++; $display("[TB] FAIL lock_underrun: o_underrun=%b expected=0", o_underrun); end
  endtask

  task automatic test_bad_period();
    exp_q.push_back(18'h15555);
    send_frame(18'h0C0C0, 32, 5, 0, 1'b1);
    exp_q.push_back(18'h0C0C0);
    send_frame(18'h03333, 31, 2, 0, 1'b1);
    total++;
    if (o_locked !== 1'b0) begin bad++; $display("[TB] FAIL bad_period_unlock: o_locked=%b expected=0", o_locked); end
    for (int f = 1; f <= 4; f++) begin
      send_frame(18'h1F00F, 32, 0, 0, 1'b1);
      if (f == 3) begin
        total++;
        if (o_locked !== 1'b0) begin bad++; $display("[TB] FAIL relock_early: o_locked=%b expected=0", o_locked); end
      end
    end
    total++;
    if (o_locked !== 1'b1) begin bad++; $display("[TB] FAIL relock: o_locked=%b expected=1", o_locked); end
    total++;
    if (o_overrun !== 1'b0) begin bad++; $display("[TB] FAIL relock_overrun: o_overrun=%b expected=0", o_overrun); end
  endtask

  task automatic test_timeout();
    exp_q.push_back(18'h1F00F);
    send_frame('0, 60, 2, 0, 1'b0);
    total++;
    if (o_locked !== 1'b1) begin bad++; $display("[TB] FAIL timeout_early: o_locked=%b expected=1", o_locked); end
    send_frame('0, 10, 0, 0, 1'b0);
    total++;
    if (o_locked !== 1'b0) begin bad++; $display("[TB] FAIL timeout_unlock: o_locked=%b expected=0", o_locked); end
    exp_q.push_back('0);
    send_frame('0, 2, 1, 0, 1'b0);
    total++;
    if (o_underrun !== 1'b0) begin bad++; $display("[TB] FAIL mute_underrun: o_underrun=%b expected=0", o_underrun); end
    total++;
    if (o_overrun !== 1'b0) begin bad++; $display("[TB] FAIL mute_overrun: o_overrun=%b expected=0", o_overrun); end
  endtask

  task automatic test_sticky_flags();
    do_reset();
    for (int f = 1; f <= 5; f++) send_frame(18'h12345, 32, 0, 0, 1'b1);
    total++;
    if (o_locked !== 1'b1) begin bad++; $display("[TB] FAIL sticky_lock: o_locked=%b expected=1", o_locked); end
    send_frame(18'h0ABCD, 32, 0, 0, 1'b1);
    total++;
    if (o_overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun_set: o_overrun=%b expected=1", o_overrun); end
    total++;
    if (o_underrun !== 1'b0) begin bad++; $display("[TB] FAIL overrun_only: o_underrun=%b expected=0", o_underrun); end
    exp_q.push_back(18'h0ABCD);
    send_frame(18'h3C3C3, 32, 3, 0, 1'b1);
    exp_q.push_back(18'h3C3C3);
    exp_q.push_back(18'h3C3C3);
    send_frame(18'h2F0F1, 32, 3, 10, 1'b1);
    total++;
    if (o_underrun !== 1'b1) begin bad++; $display("[TB] FAIL underrun_set: o_underrun=%b expected=1", o_underrun); end
    exp_q.push_back(18'h2F0F1);
    send_frame(18'h1E1E1, 32, 3, 0, 1'b1);
    total++;
    if (o_overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun_sticky: o_overrun=%b expected=1", o_overrun); end
    total++;
    if (o_underrun !== 1'b1) begin bad++; $display("[TB] FAIL underrun_sticky: o_underrun=%b expected=1", o_underrun); end
  endtask

  task automatic test_coincident();
    do_reset();
    for (int f = 1; f <= 5; f++) send_frame(18'h0A5A5, 32, 0, 0, 1'b1);
    exp_q.push_back(18'h0A5A5);
    send_frame(18'h35A5A, 32, 32, 0, 1'b1);
    total++;
    if (o_overrun !== 1'b0) begin bad++; $display("[TB] FAIL coincident_overrun: o_overrun=%b expected=0", o_overrun); end
    exp_q.push_back(18'h35A5A);
    send_frame(18'h11111, 32, 3, 0, 1'b1);
    total++;
    if (o_underrun !== 1'b0) begin bad++; $display("[TB] FAIL coincident_pending: o_underrun=%b expected=0", o_underrun); end
  endtask

  task automatic test_midframe_reset();
    send_frame(18'h22222, 32, 0, 0, 1'b1);
    exp_q.push_back(18'h22222);
    exp_q.push_back(18'h22222);
    send_frame(18'h33333, 32, 3, 6, 1'b1);
    total++;
    if ((o_overrun !== 1'b1) || (o_underrun !== 1'b1)) begin
      bad++;
      $display("[TB] FAIL pre_reset_flags: overrun=%b underrun=%b expected=1,1", o_overrun, o_underrun);
    end
    send_frame(18'h3FFFF, 10, 0, 0, 1'b0);
    i_rst            = 1'b1;
    i_ad_latch_pulse = 1'b1;
    i_ad_data        = 1'b1;
    i_i2s_latch      = 1'b1;
    cycle();
    i_rst = 1'b0;
    clear_inputs();
    total++;
    if (o_data !== '0) begin bad++; $display("[TB] FAIL midreset_data: o_data=%h expected=0", o_data); end
    total++;
    if (o_locked !== 1'b0) begin bad++; $display("[TB] FAIL midreset_locked: o_locked=%b expected=0", o_locked); end
    total++;
    if (o_overrun !== 1'b0) begin bad++; $display("[TB] FAIL midreset_overrun: o_overrun=%b expected=0", o_overrun); end
    total++;
    if (o_underrun !== 1'b0) begin bad++; $display("[TB] FAIL midreset_underrun: o_underrun=%b expected=0", o_underrun); end
    exp_q.push_back('0);
    send_frame(18'h24680, 32, 3, 0, 1'b1);
    for (int f = 2; f <= 5; f++) begin
      send_frame(18'h24680, 32, 0, 0, 1'b1);
      if (f == 4) begin
        total++;
        if (o_locked !== 1'b0) begin bad++; $display("[TB] FAIL midreset_relock_early: o_locked=%b expected=0", o_locked); end
      end
    end
    total++;
    if (o_locked !== 1'b1) begin bad++; $display("[TB] FAIL midreset_relock: o_locked=%b expected=1", o_locked); end
    exp_q.push_back(18'h24680);
    send_frame(18'h13579, 32, 3, 0, 1'b1);
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_lock_delivery();
    test_bad_period();
    test_timeout();
    test_sticky_flags();
    test_coincident();
    test_midframe_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_leftover: queued=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
